// File: rtl/gprs_mp.sv
// Multi-port GPR file: NUM_RD async read ports, two prioritised sync write ports, sweep init engine.
// Latency: reads combinational; writes visible next cycle (same cycle with GPRS_BYPASS_EN defined).
// Backpressure: ready=0 while the sweep runs; writes are dropped and reads return INIT_VAL.
module gprs_mp #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int          NUM_RD   = 2,
    parameter int unsigned INIT_VAL = 0,
    parameter int          ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    output logic                     ready,
    output logic [ADDR_W-1:0]        init_ptr
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] INIT_D = DATA_W'(INIT_VAL);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
    localparam logic              ZR     = (ZERO_REG != 0);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            state;
    logic [DATA_W-1:0] rf [DEPTH];
    logic              wr0_ok;
    logic              wr1_ok;

    // A write is live only in RUN and never targets the hardwired zero entry.
    assign wr0_ok = we0 && (state == S_RUN) && !(ZR && (wa0 == '0));
    assign wr1_ok = we1 && (state == S_RUN) && !(ZR && (wa1 == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            init_ptr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_ptr <= init_ptr + ADDR_W'(1);
                    if (init_ptr == LAST) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (clr) begin
                        state    <= S_INIT;
                        init_ptr <= '0;
                        ready    <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_INIT;
                    init_ptr <= '0;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; the sweep is what gives it defined contents.
    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            if (!rst && !(ZR && (init_ptr == '0)))
                rf[init_ptr] <= INIT_D;
        end else begin
            if (wr0_ok)
                rf[wa0] <= wd0;
            if (wr1_ok)
                rf[wa1] <= wd1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;

        assign a = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            v = rf[a];
            if (ZR && (a == '0))
                v = '0;
            else if (state == S_INIT)
                v = INIT_D;
`ifdef GPRS_BYPASS_EN
            else if (wr1_ok && (wa1 == a))
                v = wd1;
            else if (wr0_ok && (wa0 == a))
                v = wd0;
`endif
        end

        assign rd[k*DATA_W +: DATA_W] = v;
    end

endmodule

// File: doc/gprs_mp.md
Name: gprs_mp

Overview:
Parametrised multi-port general-purpose register file, the successor to the current 32x32 two-read/one-write GPR array.
- Configurable width, depth and read-port count.
- Two prioritised synchronous write ports; optional hardwired zero register.
- Sequential one-entry-per-cycle initialisation engine, started by reset or by a clear request, with a ready flag for the pipeline.
- Sits between decode (read addresses) and writeback (ALU result port 0, load/late result port 1).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of asynchronous read ports (1..4)
INIT_VAL, 0, value written to every entry by the init engine (truncated to DATA_W)
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
clr  in  1  request re-initialisation of all entries (sampled only when ready=1)
ra  in  NUM_RD*ADDR_W  read addresses; port k = ra[k*ADDR_W +: ADDR_W]
rd  out  NUM_RD*DATA_W  read data; port k = rd[k*DATA_W +: DATA_W]
we0  in  1  write enable, port 0
wa0  in  ADDR_W  write address, port 0
wd0  in  DATA_W  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  ADDR_W  write address, port 1
wd1  in  DATA_W  write data, port 1
ready  out  1  1 = array initialised, writes accepted
init_ptr  out  ADDR_W  current init entry index (debug/visibility)

Behaviour:
- FSM states INIT and RUN; state updates on the clk rising edge only.
- rst=1 at an edge: state<=INIT, init_ptr<=0, ready<=0. This applies in any state, including mid-INIT, which restarts from 0. Array contents are not cleared by rst itself.
- INIT, each edge with rst=0: rf[init_ptr]<=INIT_VAL, init_ptr<=init_ptr+1. On the edge that writes entry DEPTH-1: state<=RUN, ready<=1, init_ptr wraps to 0.
- ready therefore rises exactly DEPTH edges after the first edge with rst=0.
- RUN with clr=1 at an edge: state<=INIT, init_ptr<=0, ready<=0. Any we0/we1 in that same cycle is still performed, then overwritten by the init sweep. clr in INIT is ignored.
- Writes (RUN only): at the edge, if we0 then rf[wa0]<=wd0; if we1 then rf[wa1]<=wd1.
- wa0==wa1 with both enabled: port 1 value is stored, port 0 is dropped.
- we0/we1 during INIT (ready=0) are discarded silently.
- ZERO_REG=1: writes to address 0 are discarded on either port. Entry 0 is not written by INIT. rd for address 0 is 0 always.
- Reads: combinational, zero latency, rd_k = rf[ra_k]. All NUM_RD ports are independent, and any ports may alias the same address.
- Reads during INIT return INIT_VAL on all ports, regardless of array contents. Address 0 still returns 0 when ZERO_REG=1.
- Reset values: ready=0, init_ptr=0, rd=INIT_VAL (0 for address 0 when ZERO_REG=1).
- No X propagation: the array is never read before the first full init sweep when the bench honours ready.

Optional Feature:
GPRS_BYPASS_EN
- Defined: write-to-read forwarding in RUN. If ra_k matches an enabled, non-discarded write this cycle, rd_k returns that write data combinationally. Port 1 data takes priority when both ports match. No forwarding for address 0 when ZERO_REG=1, and none during INIT.
- Undefined: rd_k returns the stored value; new data becomes visible the cycle after the write edge.

Test Plan:
- Init timing: DATA_W=32, ADDR_W=5, INIT_VAL=2. Pulse rst for 1 edge. Then ready=0 for 32 edges and ready=1 after the 32nd edge; all 31 non-zero entries read 2 and entry 0 reads 0.
- Dual-write collision: RUN, we0=1 wa0=7 wd0=0x1111, we1=1 wa1=7 wd1=0x2222 → next cycle rd0(ra=7)=0x2222. Then separate addresses 3/4 with 0xA/0xB → both stored.
- Zero register: we1=1 wa1=0 wd1=0xFFFFFFFF → rd for address 0 = 0 on every port. Repeat with ZERO_REG=0 → 0xFFFFFFFF.
- Bypass: we0=1 wa0=5 wd0=0x55, ra port 1=5 in the same cycle → with GPRS_BYPASS_EN rd1=0x55 immediately. Without it, rd1 shows the old value, then 0x55 after the edge.
- clr and reset mid-sweep: in RUN write 0x99 to entry 9, assert clr for 1 cycle → ready=0. Assert rst when init_ptr=10 → init_ptr=0 next cycle. Writes during INIT are ignored. After ready rises, entry 9 reads INIT_VAL.
- Multi-port: NUM_RD=4, all ra=12 with rf[12]=0xCAFE → all four rd=0xCAFE. Mixed addresses 1/2/3/4 → matching stored values.
